fcl_dyna_responder: RTL and testbench
=====================================

FCL_DYNA_RESPONDER -- requirements
Module: fcl_dyna_responder

Interface
REQ-001 The block SHALL have parameter SERVO_ID, default 8'h01, the node ID answered by this responder.
REQ-002 The block SHALL have parameter RETURN_DELAY_COUNT, default 250, the clk_in cycles from checksum byte receipt to the first status byte send.
REQ-003 The block SHALL have parameter RX_TIMEOUT_COUNT, default 2500, the maximum idle clk_in cycles allowed between bytes inside one packet.
REQ-004 The block SHALL have port clk_in, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_in, input, 1 bit, a synchronous active-high reset.
REQ-006 The block SHALL have ports rx_data_in (input, 8) and rx_data_valid_in (input, 1), a received UART byte qualified by a 1-cycle valid.
REQ-007 The block SHALL have ports tx_data_out (output, 8), tx_data_send_out (output, 1) and tx_done_in (input, 1), the UART transmit byte, 1-cycle send pulse and byte-complete pulse.
REQ-008 The block SHALL have port present_pos_in, input, 10 bits, the present position exposed at registers 0x24/0x25.
REQ-009 The block SHALL have ports goal_pos_out (output, 10) and goal_pos_we_out (output, 1), the goal register and its 1-cycle update strobe.
REQ-010 The block SHALL have port led_out, output, 1 bit, bit 0 of register 0x19.
REQ-011 The block SHALL have port chk_error_count_out, output, 8 bits, a saturating count of checksum failures.
REQ-012 The block SHALL have port busy_out, output, 1 bit, high whenever the FSM is not in HDR0.

Function
REQ-013 The FSM SHALL have states HDR0, HDR1, ID, LEN, INST, PARAM, CHK, EXEC, DELAY, TX_SEND, TX_WAIT.
REQ-014 Header handling SHALL be: HDR0 to HDR1 on byte FF; HDR1 to ID on FF, otherwise to HDR0; in ID an extra FF keeps the FSM in ID.
REQ-015 A packet SHALL be accepted for this node when the ID equals SERVO_ID or FE (broadcast); any other ID is still parsed to the end, then discarded with no action.
REQ-016 If LEN < 2 or LEN > 8, the FSM SHALL return to HDR0 silently; the parameter count is LEN-2, with params stored in an internal 6-byte buffer.
REQ-017 The checksum SHALL be the 8-bit value ~(ID+LEN+INST+params), modulo 256.
REQ-018 On a checksum mismatch with an accepted non-broadcast ID, the block SHALL increment chk_error_count_out (saturating at FF), execute nothing, and reply with error byte 8'h10.
REQ-019 INST 01 (ping) SHALL reply with no params.
REQ-020 INST 02 (read), params addr and n with n in 1..4, SHALL reply with n bytes; register values are 0x19={7'b0,led}, 0x1E/0x1F=goal low/high, 0x24/0x25=present low/high, and any other address reads 00; n outside 1..4 SHALL reply with error 8'h08 and no params.
REQ-021 INST 03 (write), params addr and data…, SHALL write sequential addresses.
REQ-022 A write SHALL commit only in EXEC, after a good checksum; writes to unmapped addresses SHALL be ignored.
REQ-023 In a write, 0x1E SHALL set goal[7:0] and 0x1F SHALL set goal[9:8] from data[1:0].
REQ-024 goal_pos_we_out SHALL pulse exactly 1 cycle, in the cycle after EXEC, if 0x1E or 0x1F was written.
REQ-025 Any other INST SHALL reply with error 8'h40.
REQ-026 present_pos_in SHALL be sampled in EXEC; read data is frozen for the whole reply.
REQ-027 Broadcast packets SHALL execute but never reply.
REQ-028 The status packet SHALL be FF FF SERVO_ID (n+2) ERR params CHK, where CHK = ~(ID+LEN+ERR+params).
REQ-029 DELAY SHALL wait RETURN_DELAY_COUNT cycles; the first tx_data_send_out then follows 1 cycle later.
REQ-030 tx_data_out SHALL be valid with tx_data_send_out and held until tx_done_in; the next send follows tx_done_in by exactly 1 cycle.
REQ-031 After the final tx_done_in, the FSM SHALL go to HDR0.
REQ-032 rx_data_valid_in SHALL be ignored during EXEC, DELAY, TX_SEND and TX_WAIT (half-duplex echo rejection).
REQ-033 In ID through CHK, an inter-byte gap exceeding RX_TIMEOUT_COUNT cycles SHALL return the FSM to HDR0 with no execution and no reply.

Reset
REQ-034 When reset_in is high at a clock edge, the block SHALL go to HDR0 and set goal_pos_out=10'h200, goal_pos_we_out=0, led_out=0, chk_error_count_out=00, tx_data_out=00, tx_data_send_out=0 and busy_out=0.
REQ-035 Reset asserted mid-packet or mid-reply SHALL abort without completing any send or write.

Verification
REQ-036 The bench SHALL cover: present_pos_in=0x1A5, rx FF FF 01 04 02 24 02 D2 -> after the delay, tx FF FF 01 04 00 A5 01 54.
REQ-037 The bench SHALL cover: rx FF FF 01 05 03 1E 34 02 A2 -> goal_pos_out=0x234 with a 1-cycle goal_pos_we_out, then tx FF FF 01 02 00 FC.
REQ-038 The bench SHALL cover: the same write with checksum A3 -> goal unchanged, chk_error_count_out=01, tx FF FF 01 02 10 EC.
REQ-039 The bench SHALL cover: the broadcast write FF FF FE 05 03 1E 00 01 DA -> goal_pos_out=0x100 and no tx_data_send_out; an ID=02 packet -> no write and no tx.
REQ-040 The bench SHALL cover: rx FF FF 01 04, then a gap of RX_TIMEOUT_COUNT+1 cycles, then a valid ping -> the first partial packet is dropped and the ping reply FF FF 01 02 00 FC is sent.
REQ-041 The bench SHALL cover: reset_in pulsed during TX_WAIT -> tx_data_send_out stays 0, busy_out=0, and the next valid read is answered normally.

Source files
------------

// File: rtl/fcl_dyna_responder_if.sv
// fcl_dyna_responder_if: UART byte stream between a transceiver (master) and the responder (slave)
//   rx_data_in/rx_data_valid_in : received byte with a 1-cycle qualifier
//   tx_data_out/tx_data_send_out: byte to transmit with a 1-cycle send pulse
//   tx_done_in                  : 1-cycle pulse when the transmitter has finished the byte
interface fcl_dyna_responder_if;
  logic [7:0] rx_data_in;
  logic       rx_data_valid_in;
  logic [7:0] tx_data_out;
  logic       tx_data_send_out;
  logic       tx_done_in;
  modport master (output rx_data_in, rx_data_valid_in, tx_done_in, input tx_data_out, tx_data_send_out);
  modport slave (input rx_data_in, rx_data_valid_in, tx_done_in, output tx_data_out, tx_data_send_out);
endinterface

// File: rtl/fcl_dyna_responder.sv
// fcl_dyna_responder: Dynamixel-style servo packet responder (ping/read/write) over a UART byte stream
//   clk_in, reset_in       : clock and synchronous active-high reset
//   bus (slave)            : rx byte stream in, tx byte stream out
//   present_pos_in         : present position, registers 0x24/0x25
//   goal_pos_out/_we_out   : goal register (0x1E/0x1F) and its 1-cycle update strobe
//   led_out                : bit 0 of register 0x19
//   chk_error_count_out    : saturating count of checksum failures addressed to this node
//   busy_out               : high whenever the parser is not waiting for a header
module fcl_dyna_responder #(
  parameter logic [7:0] SERVO_ID           = 8'h01,
  parameter int         RETURN_DELAY_COUNT = 250,
  parameter int         RX_TIMEOUT_COUNT   = 2500
) (
  input  logic                       clk_in,
  input  logic                       reset_in,
  fcl_dyna_responder_if.slave        bus,
  input  logic [9:0]                 present_pos_in,
  output logic [9:0]                 goal_pos_out,
  output logic                       goal_pos_we_out,
  output logic                       led_out,
  output logic [7:0]                 chk_error_count_out,
  output logic                       busy_out
);
  typedef enum logic [3:0] {HDR0, HDR1, ID, LEN, INST, PARAM, CHK, EXEC, DELAY, TX_SEND, TX_WAIT} state_t;
  localparam int TMAX = RETURN_DELAY_COUNT > RX_TIMEOUT_COUNT ? RETURN_DELAY_COUNT : RX_TIMEOUT_COUNT;
  localparam int TW = $clog2(TMAX + 2);
  state_t st, nxt;
  logic [7:0] rx_d, id_q, inst_q, sum_q, err_q, chk_q, rd_n, err_e, chk_e, tx_byte;
  logic [7:0] prm [6];
  logic [7:0] rp [4];
  logic [7:0] rp_e [4];
  logic [3:0] len_q, plen, tx_idx;
  logic [2:0] pidx, n_q, n_e;
  logic [TW-1:0] tmr;
  logic rx_v, chk_ok, mine, bcast, rx_to, dly_done, last, rd_ok;
  function automatic logic [7:0] reg_rd(input logic [7:0] a, input logic [9:0] g, input logic l, input logic [9:0] p);
    return a == 8'h19 ? {7'b0, l} : a == 8'h1E ? g[7:0] : a == 8'h1F ? {6'b0, g[9:8]} :
           a == 8'h24 ? p[7:0] : a == 8'h25 ? {6'b0, p[9:8]} : 8'h00;
  endfunction
  assign rx_d = bus.rx_data_in;
  assign rx_v = bus.rx_data_valid_in;
  assign plen = len_q - 4'd2;
  assign bcast = id_q == 8'hFE;
  assign mine = id_q == SERVO_ID || bcast;
  // the timer counts idle cycles while parsing, so a gap only expires when it exceeds the limit
  assign rx_to = !rx_v && tmr == TW'(RX_TIMEOUT_COUNT);
  assign dly_done = tmr + 1'b1 >= TW'(RETURN_DELAY_COUNT);
  assign last = tx_idx == 4'd5 + {1'b0, n_q};
  // reply contents are settled in EXEC; read data is captured there and frozen for the reply
  assign rd_n = len_q >= 4'd4 ? prm[1] : 8'h00;
  assign rd_ok = rd_n >= 8'd1 && rd_n <= 8'd4;
  assign err_e = !chk_ok ? 8'h10 : inst_q == 8'h01 || inst_q == 8'h03 ? 8'h00 :
                 inst_q == 8'h02 ? (rd_ok ? 8'h00 : 8'h08) : 8'h40;
  assign n_e = chk_ok && inst_q == 8'h02 && rd_ok ? rd_n[2:0] : 3'd0;
  always_comb begin
    chk_e = SERVO_ID + {5'b0, n_e} + 8'd2 + err_e;
    for (int i = 0; i < 4; i++) begin
      rp_e[i] = reg_rd(prm[0] + 8'(i), goal_pos_out, led_out, present_pos_in);
      chk_e = chk_e + (3'(i) < n_e ? rp_e[i] : 8'h00);
    end
    chk_e = ~chk_e;
  end
  always_comb begin
    nxt = st;
    case (st)
      HDR0:    nxt = rx_v && rx_d == 8'hFF ? HDR1 : HDR0;
      HDR1:    nxt = !rx_v ? HDR1 : rx_d == 8'hFF ? ID : HDR0;
      ID:      nxt = rx_to ? HDR0 : !rx_v || rx_d == 8'hFF ? ID : LEN;
      LEN:     nxt = rx_to ? HDR0 : !rx_v ? LEN : rx_d < 8'd2 || rx_d > 8'd8 ? HDR0 : INST;
      INST:    nxt = rx_to ? HDR0 : !rx_v ? INST : plen == 4'd0 ? CHK : PARAM;
      PARAM:   nxt = rx_to ? HDR0 : !rx_v ? PARAM : {1'b0, pidx} == plen - 4'd1 ? CHK : PARAM;
      // foreign IDs and corrupted broadcasts end silently; a corrupted unicast still gets an error reply
      CHK:     nxt = rx_to ? HDR0 : !rx_v ? CHK : !mine || (bcast && rx_d != ~sum_q) ? HDR0 : EXEC;
      EXEC:    nxt = bcast ? HDR0 : DELAY;
      DELAY:   nxt = dly_done ? TX_SEND : DELAY;
      TX_SEND: nxt = TX_WAIT;
      TX_WAIT: nxt = !bus.tx_done_in ? TX_WAIT : last ? HDR0 : TX_SEND;
      default: nxt = HDR0;
    endcase
  end
  always_ff @(posedge clk_in) st <= reset_in ? HDR0 : nxt;
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      goal_pos_out <= 10'h200;
      goal_pos_we_out <= 1'b0;
      led_out <= 1'b0;
      chk_error_count_out <= 8'h00;
      tmr <= '0;
      tx_idx <= 4'd0;
    end else begin
      goal_pos_we_out <= 1'b0;
      tmr <= st >= ID && st <= CHK ? (rx_v ? '0 : tmr + 1'b1) : st == DELAY ? tmr + 1'b1 : '0;
      if (st == CHK && rx_v && mine && !bcast && rx_d != ~sum_q && chk_error_count_out != 8'hFF)
        chk_error_count_out <= chk_error_count_out + 8'd1;
      if (st == EXEC) tx_idx <= 4'd0;
      if (st == TX_WAIT && bus.tx_done_in) tx_idx <= tx_idx + 4'd1;
      if (st == EXEC && chk_ok && inst_q == 8'h03)
        for (int k = 1; k < 6; k++)
          if (4'(k) < plen)
            case (prm[0] + 8'(k - 1))
              8'h19: led_out <= prm[k][0];
              8'h1E: begin goal_pos_out[7:0] <= prm[k]; goal_pos_we_out <= 1'b1; end
              8'h1F: begin goal_pos_out[9:8] <= prm[k][1:0]; goal_pos_we_out <= 1'b1; end
              default: ;
            endcase
    end
  end
  always_ff @(posedge clk_in) begin
    if (rx_v && st == ID) begin id_q <= rx_d; sum_q <= rx_d; end
    if (rx_v && st == LEN) begin len_q <= rx_d[3:0]; sum_q <= sum_q + rx_d; end
    if (rx_v && st == INST) begin inst_q <= rx_d; sum_q <= sum_q + rx_d; pidx <= 3'd0; end
    if (rx_v && st == PARAM) begin prm[pidx] <= rx_d; sum_q <= sum_q + rx_d; pidx <= pidx + 3'd1; end
    if (rx_v && st == CHK) chk_ok <= rx_d == ~sum_q;
    if (st == EXEC) begin
      err_q <= err_e;
      n_q <= n_e;
      rp <= rp_e;
      chk_q <= chk_e;
    end
  end
  assign tx_byte = tx_idx < 4'd2 ? 8'hFF : tx_idx == 4'd2 ? SERVO_ID : tx_idx == 4'd3 ? {5'b0, n_q} + 8'd2 :
                   tx_idx == 4'd4 ? err_q : last ? chk_q : rp[2'(tx_idx - 4'd5)];
  assign bus.tx_data_out = st == TX_SEND || st == TX_WAIT ? tx_byte : 8'h00;
  assign bus.tx_data_send_out = st == TX_SEND;
  assign busy_out = st != HDR0;
endmodule

// File: tb/tb_fcl_dyna_responder.sv
// tb_fcl_dyna_responder: scoreboard bench for fcl_dyna_responder with directed packets
module tb_fcl_dyna_responder;
  localparam int RDC = 20;
  localparam int RTO = 50;
  logic clk_in = 1'b0;
  logic reset_in = 1'b1;
  logic [9:0] present_pos_in = 10'h1A5;
  logic [9:0] goal_pos_out;
  logic goal_pos_we_out, led_out, busy_out;
  logic [7:0] chk_error_count_out;
  int checks = 0, failures = 0, we_cnt = 0, w0 = 0, d = 0, s = 0;
  logic [7:0] exp_q[$];
  fcl_dyna_responder_if bus();
  fcl_dyna_responder #(.SERVO_ID(8'h01), .RETURN_DELAY_COUNT(RDC), .RX_TIMEOUT_COUNT(RTO)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .bus(bus), .present_pos_in(present_pos_in),
    .goal_pos_out(goal_pos_out), .goal_pos_we_out(goal_pos_we_out), .led_out(led_out),
    .chk_error_count_out(chk_error_count_out), .busy_out(busy_out));
  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic rx_pkt(input int n, input logic [95:0] v);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      bus.rx_data_in = v[8*(n-1-i) +: 8];
      bus.rx_data_valid_in = 1'b1;
      @(negedge clk_in);
      bus.rx_data_valid_in = 1'b0;
    end
  endtask

  task automatic exp_tx(input int n, input logic [95:0] v);
    for (int i = 0; i < n; i++) exp_q.push_back(v[8*(n-1-i) +: 8]);
  endtask

  task automatic wait_idle;
    int i = 0;
    while ((busy_out || exp_q.size() != 0) && i < 3000) begin
      @(negedge clk_in);
      i++;
    end
    chk("idle_reached", i < 3000, 1);
    repeat (4) @(negedge clk_in);
  endtask

  // transmit-side monitor: pops the scoreboard on every send and acknowledges the byte
  initial begin
    logic [7:0] e;
    bus.tx_done_in = 1'b0;
    forever begin
      if (bus.tx_data_send_out === 1'b1) begin
        e = bus.tx_data_out;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_tx: got %0h expected no send", e);
        end else chk("tx_byte", e, exp_q.pop_front());
        @(negedge clk_in);
        chk("send_pulse", bus.tx_data_send_out, 0);
        repeat (2) @(negedge clk_in);
        if (busy_out) chk("tx_hold", bus.tx_data_out, e);
        bus.tx_done_in = 1'b1;
        @(negedge clk_in);
        bus.tx_done_in = 1'b0;
      end else @(negedge clk_in);
    end
  end

  initial forever begin
    @(negedge clk_in);
    if (goal_pos_we_out) we_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_data_in = 8'h00;
    bus.rx_data_valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_goal", goal_pos_out, 10'h200);
    chk("rst_we", goal_pos_we_out, 0);
    chk("rst_led", led_out, 0);
    chk("rst_cnt", chk_error_count_out, 0);
    chk("rst_txd", bus.tx_data_out, 0);
    chk("rst_send", bus.tx_data_send_out, 0);
    chk("rst_busy", busy_out, 0);
    reset_in = 1'b0;
    // read present position
    exp_tx(8, 64'hFFFF010400A50154);
    rx_pkt(8, 64'hFFFF0104022402D2);
    d = 0;
    while (bus.tx_data_send_out !== 1'b1 && d < 500) begin
      @(negedge clk_in);
      d++;
    end
    chk("reply_delay", d >= RDC && d <= RDC + 2, 1);
    wait_idle;
    // goal write
    w0 = we_cnt;
    exp_tx(6, 48'hFFFF010200FC);
    rx_pkt(9, 72'hFFFF0105031E3402A2);
    wait_idle;
    chk("wr_goal", goal_pos_out, 10'h234);
    chk("wr_we_pulses", we_cnt - w0, 1);
    // same write, bad checksum
    w0 = we_cnt;
    exp_tx(6, 48'hFFFF010210EC);
    rx_pkt(9, 72'hFFFF0105031E3402A3);
    wait_idle;
    chk("bad_goal", goal_pos_out, 10'h234);
    chk("bad_cnt", chk_error_count_out, 8'h01);
    chk("bad_we", we_cnt - w0, 0);
    // broadcast write: executes, no reply
    w0 = we_cnt;
    rx_pkt(9, 72'hFFFFFE05031E0001DA);
    wait_idle;
    chk("bc_goal", goal_pos_out, 10'h100);
    chk("bc_we", we_cnt - w0, 1);
    // foreign ID: no action
    w0 = we_cnt;
    rx_pkt(9, 72'hFFFF0205031E3402A1);
    wait_idle;
    chk("other_goal", goal_pos_out, 10'h100);
    chk("other_we", we_cnt - w0, 0);
    // LED write
    w0 = we_cnt;
    exp_tx(6, 48'hFFFF010200FC);
    rx_pkt(8, 64'hFFFF0104031901DD);
    wait_idle;
    chk("led", led_out, 1);
    chk("led_we", we_cnt - w0, 0);
    // read goal registers
    exp_tx(8, 64'hFFFF0104000001F9);
    rx_pkt(8, 64'hFFFF0104021E02D8);
    wait_idle;
    // read with illegal length
    exp_tx(6, 48'hFFFF010208F4);
    rx_pkt(8, 64'hFFFF0104022405CF);
    wait_idle;
    // unknown instruction
    exp_tx(6, 48'hFFFF010240BC);
    rx_pkt(6, 48'hFFFF010207F5);
    wait_idle;
    // inter-byte timeout drops the partial packet
    rx_pkt(4, 32'hFFFF0104);
    repeat (RTO + 1) @(negedge clk_in);
    exp_tx(6, 48'hFFFF010200FC);
    rx_pkt(6, 48'hFFFF010201FB);
    wait_idle;
    chk("to_cnt", chk_error_count_out, 8'h01);
    // reset while waiting for tx_done
    exp_tx(1, 8'hFF);
    rx_pkt(8, 64'hFFFF0104022402D2);
    d = 0;
    while (bus.tx_data_send_out !== 1'b1 && d < 500) begin
      @(negedge clk_in);
      d++;
    end
    chk("rst_send_seen", d < 500, 1);
    @(negedge clk_in);
    reset_in = 1'b1;
    @(negedge clk_in);
    reset_in = 1'b0;
    chk("midrst_busy", busy_out, 0);
    chk("midrst_send", bus.tx_data_send_out, 0);
    chk("midrst_goal", goal_pos_out, 10'h200);
    s = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (bus.tx_data_send_out) s++;
    end
    chk("midrst_no_tx", s, 0);
    exp_tx(8, 64'hFFFF010400A50154);
    rx_pkt(8, 64'hFFFF0104022402D2);
    wait_idle;
    chk("exp_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
